// File: rtl/rgmii_tx_framer.sv
// Ethernet MAC transmit framer: preamble/SFD, zero pad, CRC-32 FCS and IFG,
// driving registered rising/falling nibble pairs into the RGMII ODDR stage.
module rgmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic       SCLK,
  input  logic       RSTN,
  input  logic [7:0] S_DATA,
  input  logic       S_VALID,
  input  logic       S_LAST,
  output logic       S_READY,
  output logic [3:0] TXD_D0,
  output logic [3:0] TXD_D1,
  output logic       TXCTL_D0,
  output logic       TXCTL_D1,
  output logic       TX_BUSY,
  output logic       TX_UNDERFLOW,
  output logic [2:0] DBG_STATE
);
  // Handshake: a byte moves on a rising SCLK edge where S_VALID && S_READY.
  // S_READY is combinational (high in DATA and DISCARD only) and never depends
  // on S_VALID; a source that drops S_VALID mid-frame in DATA causes an underflow.
  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_DISCARD, ST_IFG
  } state_t;

  localparam int PHW = 8;

  state_t         state, state_nx;
  logic [PHW-1:0] phase;
  logic [6:0]     cnt, cnt_inc;
  logic [31:0]    crc, fcs_word;
  logic           xfer;
  logic [7:0]     byte_nx;
  logic           en_nx, er_nx, uf_nx;

  // Reflected CRC-32, one byte per call, LSB of the data first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign S_READY   = (state == ST_DATA) || (state == ST_DISCARD);
  assign xfer      = S_VALID && S_READY;
  assign cnt_inc   = (cnt == 7'(MIN_PAYLOAD)) ? cnt : cnt + 7'd1;
  assign fcs_word  = ~crc;
  assign DBG_STATE = state;

  always_ff @(posedge SCLK) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (S_VALID) state_nx = ST_PRE;
      ST_PRE:     if (phase == PHW'(PREAMBLE_LEN - 1)) state_nx = ST_SFD;
      ST_SFD:     state_nx = ST_DATA;
      ST_DATA: begin
        if (!S_VALID)   state_nx = ST_DISCARD;
        else if (S_LAST) state_nx = (cnt_inc < 7'(MIN_PAYLOAD)) ? ST_PAD : ST_FCS;
      end
      ST_PAD:     if (cnt_inc == 7'(MIN_PAYLOAD)) state_nx = ST_FCS;
      ST_FCS:     if (phase == PHW'(3)) state_nx = ST_IFG;
      ST_DISCARD: if (xfer && S_LAST) state_nx = ST_IFG;
      ST_IFG: begin
        // Going straight to PRE keeps the gap at exactly IFG_BYTES idle bytes.
        if (phase == PHW'(IFG_BYTES - 1)) state_nx = S_VALID ? ST_PRE : ST_IDLE;
      end
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_nx = 8'h00;
    en_nx   = 1'b0;
    er_nx   = 1'b0;
    uf_nx   = 1'b0;
    case (state)
      ST_PRE: begin byte_nx = 8'h55; en_nx = 1'b1; end
      ST_SFD: begin byte_nx = 8'hD5; en_nx = 1'b1; end
      ST_DATA: begin
        en_nx = 1'b1;
        if (S_VALID) byte_nx = S_DATA;
        else begin er_nx = 1'b1; uf_nx = 1'b1; end
      end
      ST_PAD: en_nx = 1'b1;
      ST_FCS: begin
        en_nx = 1'b1;
        case (phase[1:0])
          2'd0:    byte_nx = fcs_word[7:0];
          2'd1:    byte_nx = fcs_word[15:8];
          2'd2:    byte_nx = fcs_word[23:16];
          default: byte_nx = fcs_word[31:24];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (!RSTN) begin
      phase <= '0;
      cnt   <= '0;
      crc   <= 32'hFFFF_FFFF;
    end else begin
      phase <= (state_nx != state) ? '0 : phase + PHW'(1);
      case (state)
        ST_SFD: begin cnt <= '0; crc <= 32'hFFFF_FFFF; end
        ST_DATA: if (xfer) begin cnt <= cnt_inc; crc <= crc32_byte(crc, S_DATA); end
        ST_PAD: begin cnt <= cnt_inc; crc <= crc32_byte(crc, 8'h00); end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SCLK) begin
    if (!RSTN) begin
      TXD_D0       <= '0;
      TXD_D1       <= '0;
      TXCTL_D0     <= 1'b0;
      TXCTL_D1     <= 1'b0;
      TX_BUSY      <= 1'b0;
      TX_UNDERFLOW <= 1'b0;
    end else begin
      TXD_D0       <= byte_nx[3:0];
      TXD_D1       <= byte_nx[7:4];
      TXCTL_D0     <= en_nx;
      TXCTL_D1     <= en_nx ^ er_nx;
      TX_BUSY      <= (state != ST_IDLE);
      TX_UNDERFLOW <= uf_nx;
    end
  end
endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Bench for rgmii_tx_framer: frames built from a byte-level model with a
// bit-serial CRC, compared against a negedge log of the RGMII outputs.
module tb_rgmii_tx_framer;
  logic       SCLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [7:0] S_DATA = 8'h00;
  logic       S_VALID = 1'b0;
  logic       S_LAST = 1'b0;
  logic       S_READY;
  logic [3:0] TXD_D0, TXD_D1;
  logic       TXCTL_D0, TXCTL_D1, TX_BUSY, TX_UNDERFLOW;
  logic [2:0] DBG_STATE;

  rgmii_tx_framer dut (
    .SCLK(SCLK), .RSTN(RSTN), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_LAST(S_LAST),
    .S_READY(S_READY), .TXD_D0(TXD_D0), .TXD_D1(TXD_D1), .TXCTL_D0(TXCTL_D0),
    .TXCTL_D1(TXCTL_D1), .TX_BUSY(TX_BUSY), .TX_UNDERFLOW(TX_UNDERFLOW),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 SCLK = ~SCLK;

  typedef struct {
    logic [3:0] d0;
    logic [3:0] d1;
    logic       en;
    logic       c1;
    logic       busy;
    logic       uf;
  } mon_t;

  mon_t       log_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         er_pos_q[$], uf_pos_q[$], gap_q[$];
  int         busy_bad, idle_bad;
  int         n_cmp = 0;
  int         n_fail = 0;

  always @(negedge SCLK)
    log_q.push_back('{TXD_D0, TXD_D1, TXCTL_D0, TXCTL_D1, TX_BUSY, TX_UNDERFLOW});

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_ref(input logic [7:0] q[$]);
    logic [31:0] r;
    logic        fb;
    r = 32'hFFFF_FFFF;
    foreach (q[i])
      for (int b = 0; b < 8; b++) begin
        fb = r[0] ^ q[i][b];
        r  = r >> 1;
        if (fb) r = r ^ 32'hEDB8_8320;
      end
    return r;
  endfunction

  task automatic fill_payload(input int len, input bit ascending);
    pay_q.delete();
    for (int i = 0; i < len; i++)
      pay_q.push_back(ascending ? 8'(i) : 8'($urandom_range(0, 255)));
  endtask

  task automatic build_expected();
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    fr = pay_q;
    while (fr.size() < 60) fr.push_back(8'h00);
    fcs = ~crc_ref(fr);
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (fr[i]) exp_q.push_back(fr[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
  endtask

  // Reduce the negedge log to EN bytes, error/underflow positions and gap lengths.
  task automatic scan_log();
    bit in_gap;
    int run;
    obs_q.delete(); er_pos_q.delete(); uf_pos_q.delete(); gap_q.delete();
    busy_bad = 0; idle_bad = 0; in_gap = 0; run = 0;
    foreach (log_q[i]) begin
      if (log_q[i].en) begin
        if (in_gap && run > 0) gap_q.push_back(run);
        if (!log_q[i].busy) busy_bad++;
        if (!log_q[i].c1) er_pos_q.push_back(obs_q.size());
        if (log_q[i].uf) uf_pos_q.push_back(obs_q.size());
        obs_q.push_back({log_q[i].d1, log_q[i].d0});
        in_gap = 1; run = 0;
      end else begin
        if (log_q[i].uf) uf_pos_q.push_back(-1);
        if (log_q[i].c1 || log_q[i].d0 != 4'h0 || log_q[i].d1 != 4'h0) idle_bad++;
        if (in_gap) begin
          if (log_q[i].busy) run++;
          else begin gap_q.push_back(run); in_gap = 0; end
        end
      end
    end
    if (in_gap && run > 0) gap_q.push_back(run);
  endtask

  // ---------------- driver ----------------
  task automatic drive_byte(input logic [7:0] d, input logic last, output bit ok);
    bit r;
    ok = 0;
    S_DATA = d; S_VALID = 1'b1; S_LAST = last;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge SCLK); r = S_READY;
      @(posedge SCLK); #1;
      if (r) ok = 1;
    end
  endtask

  task automatic send_range(input int from, input int to, output bit ok);
    bit got;
    ok = 1;
    for (int i = from; i < to; i++) begin
      drive_byte(pay_q[i], i == pay_q.size() - 1, got);
      if (!got) begin ok = 0; break; end
    end
  endtask

  task automatic idle_inputs();
    S_VALID = 1'b0; S_LAST = 1'b0; S_DATA = 8'h00;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge SCLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RSTN = 1'b0; S_VALID = 1'b1;
    repeat (3) @(posedge SCLK);
    @(negedge SCLK);
    n_cmp++;
    if ({TXD_D0, TXD_D1, TXCTL_D0, TXCTL_D1, TX_BUSY, TX_UNDERFLOW} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h exp 0", {TXD_D0, TXD_D1, TXCTL_D0, TXCTL_D1, TX_BUSY, TX_UNDERFLOW});
    end
    n_cmp++;
    if (S_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b exp 0", S_READY); end
    RSTN = 1'b1; S_VALID = 1'b0;
    run_cycles(2);
    n_cmp++;
    if (DBG_STATE !== 3'd0 || TX_BUSY !== 1'b0 || TXCTL_D0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got state %0d busy %b en %b exp 0 0 0", DBG_STATE, TX_BUSY, TXCTL_D0);
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    logic [7:0]  res_q[$];
    logic [31:0] res;
    log_q.delete(); exp_q.delete();
    fill_payload(64, 1'b1);
    build_expected();
    send_range(0, 64, ok);
    idle_inputs();
    run_cycles(100);
    scan_log();
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL full_accept: got timeout exp 64 transfers"); end
    n_cmp++;
    if (obs_q.size() != 76) begin n_fail++; $display("FAIL full_len: got %0d exp 76", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL full_byte[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 8; i < obs_q.size(); i++) res_q.push_back(obs_q[i]);
    res = crc_ref(res_q);
    n_cmp++;
    if (res !== 32'hDEBB_20E3) begin n_fail++; $display("FAIL full_residue: got %h exp DEBB20E3", res); end
    n_cmp++;
    if (er_pos_q.size() != 0 || uf_pos_q.size() != 0) begin
      n_fail++; $display("FAIL full_ctl: got %0d er %0d uf exp 0 0", er_pos_q.size(), uf_pos_q.size());
    end
    n_cmp++;
    if (gap_q.size() != 1 || gap_q[0] != 12) begin
      n_fail++; $display("FAIL full_ifg: got %0d gaps first %0d exp 1 gap of 12", gap_q.size(), gap_q.size() > 0 ? gap_q[0] : -1);
    end
    n_cmp++;
    if (busy_bad != 0 || idle_bad != 0 || log_q[log_q.size()-1].busy !== 1'b0) begin
      n_fail++; $display("FAIL full_busy_idle: got busy_bad %0d idle_bad %0d exp 0 0, busy low at end", busy_bad, idle_bad);
    end
  endtask

  task automatic test_padding(input int len, input string name);
    bit ok;
    int g12;
    log_q.delete(); exp_q.delete();
    fill_payload(len, 1'b0);
    build_expected();
    send_range(0, len, ok);
    idle_inputs();
    run_cycles(120);
    scan_log();
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL %s_accept: got timeout exp %0d transfers", name, len); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_len: got %0d exp %0d", name, obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_byte[%0d]: got %h exp %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    g12 = 0;
    foreach (gap_q[i]) if (gap_q[i] == 12) g12++;
    n_cmp++;
    if (gap_q.size() != 1 || g12 != 1) begin
      n_fail++; $display("FAIL %s_ifg: got %0d gaps (%0d of 12) exp 1", name, gap_q.size(), g12);
    end
    n_cmp++;
    if (er_pos_q.size() != 0 || uf_pos_q.size() != 0 || busy_bad != 0 || idle_bad != 0) begin
      n_fail++; $display("FAIL %s_ctl: got er %0d uf %0d busy_bad %0d idle_bad %0d exp all 0",
                         name, er_pos_q.size(), uf_pos_q.size(), busy_bad, idle_bad);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) test_padding($urandom_range(1, 90), $sformatf("rand%0d", f));
  endtask

  task automatic test_underflow();
    bit ok1, ok2;
    log_q.delete(); exp_q.delete();
    fill_payload(12, 1'b0);
    build_expected();
    send_range(0, 5, ok1);
    idle_inputs();
    run_cycles(1);
    send_range(5, 12, ok2);
    idle_inputs();
    run_cycles(60);
    scan_log();
    n_cmp++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL uf_accept: got timeout exp all 12 bytes taken"); end
    n_cmp++;
    if (obs_q.size() != 14) begin n_fail++; $display("FAIL uf_len: got %0d exp 14", obs_q.size()); end
    for (int i = 0; i < 13 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL uf_byte[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs_q.size() > 13 && obs_q[13] !== 8'h00) begin
      n_fail++; $display("FAIL uf_err_byte: got %h exp 00", obs_q[13]);
    end
    n_cmp++;
    if (er_pos_q.size() != 1 || er_pos_q[0] != 13) begin
      n_fail++; $display("FAIL uf_txctl: got %0d error bytes exp 1 at index 13", er_pos_q.size());
    end
    n_cmp++;
    if (uf_pos_q.size() != 1 || uf_pos_q[0] != 13) begin
      n_fail++; $display("FAIL uf_pulse: got %0d pulses exp 1 aligned with error byte", uf_pos_q.size());
    end
    n_cmp++;
    if (gap_q.size() != 1 || gap_q[0] != 7 + 12) begin
      n_fail++; $display("FAIL uf_drop_ifg: got %0d gaps first %0d exp 1 gap of 19", gap_q.size(), gap_q.size() > 0 ? gap_q[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int g12;
    log_q.delete(); exp_q.delete();
    fill_payload($urandom_range(1, 70), 1'b0);
    build_expected();
    send_range(0, pay_q.size(), ok1);
    fill_payload($urandom_range(1, 70), 1'b0);
    build_expected();
    send_range(0, pay_q.size(), ok2);
    idle_inputs();
    run_cycles(120);
    scan_log();
    n_cmp++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_accept: got timeout exp both frames taken"); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_len: got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_byte[%0d]: got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    g12 = 0;
    foreach (gap_q[i]) if (gap_q[i] == 12) g12++;
    n_cmp++;
    if (gap_q.size() != 2 || g12 != 2) begin
      n_fail++; $display("FAIL b2b_gap: got %0d gaps (%0d of 12) exp 2 gaps of 12", gap_q.size(), g12);
    end
  endtask

  task automatic test_reset_in_pad();
    bit ok;
    log_q.delete(); exp_q.delete();
    fill_payload(10, 1'b0);
    send_range(0, 10, ok);
    idle_inputs();
    run_cycles(10);
    RSTN = 1'b0;
    @(negedge SCLK);
    RSTN = 1'b0;
    @(posedge SCLK);
    @(negedge SCLK);
    n_cmp++;
    if ({TXD_D0, TXD_D1, TXCTL_D0, TXCTL_D1, TX_BUSY, TX_UNDERFLOW, S_READY} !== 15'h0) begin
      n_fail++;
      $display("FAIL pad_reset_outputs: got %h exp 0", {TXD_D0, TXD_D1, TXCTL_D0, TXCTL_D1, TX_BUSY, TX_UNDERFLOW, S_READY});
    end
    RSTN = 1'b1;
    run_cycles(3);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL pad_reset_accept: got timeout exp 10 transfers"); end
    test_padding(17, "after_reset");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_full_frame();
    test_padding(10, "pad10");
    test_random_frames();
    test_underflow();
    test_back_to_back();
    test_reset_in_pad();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
